uba_intr_arb: RTL and testbench
===============================

// Module: uba_intr_arb
// PURPOSE
//   IO Bridge (UBA) interrupt arbiter and vector sequencer. Maps device bus
//   requests (BR7..BR4) onto the PI levels held in UBASR[PIH]/UBASR[PIL].
//   Services CPU interrupt-acknowledge cycles by granting one device, capturing
//   its vector and returning it to the backplane. A non-responding device is
//   reported to UBASR as an adapter timeout (TMO).
// PARAMETERS
//   TIMEOUT  64  cycles in WAIT without a device vector before abort (2..255)
// PORTS
//   clk         in   1      clock
//   rst         in   1      asynchronous reset, ACTIVE-LOW
//   devINTR     in   4x4    [7:4] per device [1:4]; bus request BR7..BR4
//   statPIH     in   3      UBASR[PIH]; 0 = high level disabled
//   statPIL     in   3      UBASR[PIL]; 0 = low level disabled
//   statINI     in   1      UBASR[INI] pulse; aborts any acknowledge cycle
//   busACKI     in   1      one-cycle interrupt-acknowledge strobe from CPU
//   busPI       in   3      PI level being acknowledged (valid with busACKI)
//   devVECT     in   4x18   [18:35] per device; interrupt vector
//   devVECTVLD  in   4      per device; vector valid while granted
//   busREQO     out  7      [1:7] PI request lines to CPU
//   devACKO     out  4x4    [7:4] per device; grant at one BR level
//   busVECT     out  18     [18:35] vector returned to CPU
//   busVECTVLD  out  1      one-cycle strobe; busVECT valid
//   setTMO      out  1      one-cycle strobe to UBASR TMO bit
// BEHAVIOUR
//   Reset: all outputs 0, FSM=IDLE, counter=0, grant registers cleared.
//   busREQO: registered, one-cycle latency from devINTR/statPIx.
//     - bit PIH is set if any device asserts BR7 or BR6 and PIH!=0.
//     - bit PIL is set if any device asserts BR5 or BR4 and PIL!=0.
//     - If PIH==PIL, the two terms are ORed.
//     - Level 0 never drives a line.
//   FSM states: IDLE -> ARB -> WAIT -> DONE -> IDLE.
//     IDLE: on busACKI, latch busPI and go to ARB. busACKI outside IDLE is ignored.
//     ARB (1 cycle): candidate set is
//       - BR7/BR6, when level==PIH;
//       - BR5/BR4, when level==PIL.
//       Pick the highest BR level first, then the lowest device number (1 beats 4).
//       Winner found: register the one-hot grant and go to WAIT.
//       No winner (request withdrawn): go to DONE with vector 0 (passive release).
//     WAIT: devACKO[winner][level] held high; counter increments each cycle.
//       - Winner devVECTVLD: latch devVECT and go to DONE.
//       - Counter reaches TIMEOUT-1 first: vector=0, setTMO pulses in the
//         DONE cycle, go to DONE.
//       - VLD and timeout in the same cycle: VLD wins, no TMO.
//       - devVECTVLD from a non-granted device is ignored.
//     DONE (1 cycle): busVECTVLD=1, busVECT driven, devACKO=0, counter cleared.
//   Minimum latency: busACKI at cycle 0 -> devACKO cycle 2.
//     VLD at cycle 2 -> busVECTVLD at cycle 3.
//   statINI: synchronously forces IDLE, clears grant and counter.
//     No busVECTVLD and no setTMO. Takes priority over every transition.
//   Async reset mid-cycle: outputs drop immediately, no strobes emitted.
//   devACKO: at most one bit set at any time; zero outside WAIT.
// TESTING
//   1. PIH=3, PIL=5, dev2 BR5 -> busREQO[5]=1 after 1 cycle.
//      busACKI PI=5 -> devACKO[2][5]=1 at cycle 2.
//      dev2 VLD vect=0o224 -> busVECT=0o224 with busVECTVLD on the next cycle.
//   2. dev1 BR4, dev3 BR7, dev4 BR6, PIH=PIL=2; ack PI=2 -> dev3 granted at BR7.
//      Repeat with only dev1 BR6 + dev4 BR6 -> dev1 granted.
//   3. Grant dev1, no VLD -> setTMO=1 and busVECT=0 exactly TIMEOUT+2 cycles
//      after busACKI. devACKO low from then on.
//   4. Ack PI=6 with no matching request, or PIH=0 -> no devACKO.
//      busVECTVLD with vector 0 at cycle 2.
//      PIH=0 with BR7 pending -> busREQO stays 0.
//   5. statINI during WAIT -> IDLE next cycle, no busVECTVLD, no setTMO.
//      busACKI issued during WAIT is ignored.
//      rst low during WAIT -> all outputs 0 immediately.

Source files
------------

// File: rtl/uba_intr_arb_if.sv
// UBA interrupt arbiter bus bundle.
// Device-side request/vector lines plus CPU-side PI/acknowledge lines.
interface uba_intr_arb_if;
    logic [1:4][7:4]   devINTR;
    logic [2:0]        statPIH;
    logic [2:0]        statPIL;
    logic              statINI;
    logic              busACKI;
    logic [2:0]        busPI;
    logic [1:4][18:35] devVECT;
    logic [1:4]        devVECTVLD;
    logic [1:7]        busREQO;
    logic [1:4][7:4]   devACKO;
    logic [18:35]      busVECT;
    logic              busVECTVLD;
    logic              setTMO;

    modport master (
        output devINTR, statPIH, statPIL, statINI,
        output busACKI, busPI, devVECT, devVECTVLD,
        input  busREQO, devACKO, busVECT, busVECTVLD, setTMO
    );

    modport slave (
        input  devINTR, statPIH, statPIL, statINI,
        input  busACKI, busPI, devVECT, devVECTVLD,
        output busREQO, devACKO, busVECT, busVECTVLD, setTMO
    );
endinterface

// File: rtl/uba_intr_arb.sv
// UBA interrupt arbiter: maps BR7..BR4 onto PI levels and runs the
// acknowledge cycle (grant one device, capture vector, report timeout).
module uba_intr_arb #(
    parameter int TIMEOUT = 64
) (
    input logic           clk,
    input logic           rst,
    uba_intr_arb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARB, WAIT, DONE} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t          state;
    state_t          stateNxt;
    logic [2:0]      level;
    logic [1:4][7:4] grant;
    logic [7:0]      cnt;
    logic [18:35]    vect;
    logic            tmo;
    logic [1:7]      reqQ;

    logic [1:7]      reqNxt;
    logic            hiReq;
    logic            loReq;
    logic [7:4]      cand;
    logic [1:4][7:4] winGrant;
    logic            winFound;
    logic [1:4]      devMask;
    logic            vldWin;
    logic [18:35]    vectSel;
    logic            cntLast;
    logic [1:4][7:4] ackOut;
    logic            vldOut;
    logic [18:35]    vectOut;
    logic            tmoOut;

    // PI request lines: fold BR7/BR6 onto PIH and BR5/BR4 onto PIL
    always_comb begin
        hiReq  = 1'b0;
        loReq  = 1'b0;
        reqNxt = '0;
        for (int d = 1; d <= 4; d++) begin
            hiReq = hiReq | bus.devINTR[d][7] | bus.devINTR[d][6];
            loReq = loReq | bus.devINTR[d][5] | bus.devINTR[d][4];
        end
        if (bus.statPIH != 3'd0 && hiReq)
            reqNxt[bus.statPIH] = 1'b1;
        if (bus.statPIL != 3'd0 && loReq)
            reqNxt[bus.statPIL] = 1'b1;
    end

    // Register the request lines (one-cycle latency)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            reqQ <= '0;
        else
            reqQ <= reqNxt;
    end

    // Winner: highest BR level first, then lowest device number
    always_comb begin
        cand[7]  = (level != 3'd0) && (level == bus.statPIH);
        cand[6]  = cand[7];
        cand[5]  = (level != 3'd0) && (level == bus.statPIL);
        cand[4]  = cand[5];
        winGrant = '0;
        winFound = 1'b0;
        for (int b = 7; b >= 4; b--) begin
            for (int d = 1; d <= 4; d++) begin
                if (!winFound && cand[b] && bus.devINTR[d][b]) begin
                    winGrant[d][b] = 1'b1;
                    winFound       = 1'b1;
                end
            end
        end
    end

    // Granted-device qualification of vector valid and vector select
    always_comb begin
        devMask = '0;
        vectSel = '0;
        for (int d = 1; d <= 4; d++) begin
            devMask[d] = |grant[d];
            if (devMask[d])
                vectSel = vectSel | bus.devVECT[d];
        end
        vldWin  = |(bus.devVECTVLD & devMask);
        cntLast = (cnt == CNT_LAST);
    end

    // Next state and state-decoded outputs
    always_comb begin
        stateNxt = state;
        ackOut   = '0;
        vldOut   = 1'b0;
        vectOut  = '0;
        tmoOut   = 1'b0;
        unique case (state)
            IDLE: if (bus.busACKI) stateNxt = ARB;
            ARB:  stateNxt = winFound ? WAIT : DONE;
            WAIT: begin
                ackOut = grant;
                if (vldWin || cntLast)
                    stateNxt = DONE;
            end
            DONE: begin
                vldOut   = 1'b1;
                vectOut  = vect;
                tmoOut   = tmo;
                stateNxt = IDLE;
            end
        endcase
        if (bus.statINI)
            stateNxt = IDLE;
    end

    // State, grant, counter and vector registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            level <= '0;
            grant <= '0;
            cnt   <= '0;
            vect  <= '0;
            tmo   <= 1'b0;
        end else begin
            state <= stateNxt;
            if (bus.statINI) begin
                grant <= '0;
                cnt   <= '0;
                tmo   <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: if (bus.busACKI) level <= bus.busPI;
                    ARB: begin
                        grant <= winGrant;
                        cnt   <= '0;
                        vect  <= '0;
                        tmo   <= 1'b0;
                    end
                    WAIT: begin
                        if (vldWin) begin
                            vect  <= vectSel;
                            grant <= '0;
                            cnt   <= '0;
                        end else if (cntLast) begin
                            tmo   <= 1'b1;
                            grant <= '0;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    DONE: begin
                        vect <= '0;
                        tmo  <= 1'b0;
                        cnt  <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.busREQO    = reqQ;
    assign bus.devACKO    = ackOut;
    assign bus.busVECTVLD = vldOut;
    assign bus.busVECT    = vectOut;
    assign bus.setTMO     = tmoOut;
endmodule

// File: tb/tb_uba_intr_arb.sv
// Bench for uba_intr_arb: vector table, corner sequences and
// randomized transactions against a priority/timing model.
module tb_uba_intr_arb;
    localparam int TO = 12;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uba_intr_arb_if bus();
    uba_intr_arb #(.TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [15:0] intr;
        int          pih;
        int          pil;
        int          pi;
        logic [6:0]  req;
        logic [15:0] gnt;
    } vec_t;

    int          nChk = 0;
    int          nFail = 0;
    vec_t        tbl[8];
    logic [17:0] vs[1:4];

    // Flattened views: device 1 / level 1 sit in the MSBs
    function automatic logic [15:0] br(int d, int b);
        return 16'(1) << ((4 - d) * 4 + (b - 4));
    endfunction

    function automatic logic [6:0] lv(int l);
        return 7'(1) << (7 - l);
    endfunction

    function automatic logic [3:0] dv(int d);
        return 4'(1) << (4 - d);
    endfunction

    function automatic bit has(logic [15:0] m, int d, int b);
        return ((m >> ((4 - d) * 4 + (b - 4))) & 16'd1) != 16'd0;
    endfunction

    function automatic logic [6:0] mReq(logic [15:0] m, int pih, int pil);
        logic [6:0] r = '0;
        bit hi = 0;
        bit lo = 0;
        for (int d = 1; d <= 4; d++) begin
            if (has(m, d, 7) || has(m, d, 6)) hi = 1;
            if (has(m, d, 5) || has(m, d, 4)) lo = 1;
        end
        for (int l = 1; l <= 7; l++)
            if ((l == pih && hi) || (l == pil && lo)) r |= lv(l);
        return r;
    endfunction

    // Score each eligible (device, level); the best score wins
    function automatic logic [15:0] mWin(logic [15:0] m, int pih, int pil, int pi);
        int best = -1;
        int bd = 0;
        int bb = 0;
        for (int d = 1; d <= 4; d++) begin
            for (int b = 4; b <= 7; b++) begin
                int sc = b * 8 + (8 - d);
                int pl = (b >= 6) ? pih : pil;
                if (has(m, d, b) && pi != 0 && pl == pi && sc > best) begin
                    best = sc;
                    bd = d;
                    bb = b;
                end
            end
        end
        return (best < 0) ? 16'd0 : br(bd, bb);
    endfunction

    function automatic int devOf(logic [15:0] g);
        int r = 0;
        for (int d = 1; d <= 4; d++)
            for (int b = 4; b <= 7; b++)
                if (has(g, d, b)) r = d;
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        nChk++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setIn(logic [15:0] m, int pih, int pil);
        bus.devINTR = m;
        bus.statPIH = 3'(pih);
        bus.statPIL = 3'(pil);
    endtask

    task automatic packVect();
        bus.devVECT = {vs[1], vs[2], vs[3], vs[4]};
    endtask

    // Ack strobe in cycle 0; returns in cycle 2
    task automatic ack(int pi);
        bus.busACKI = 1'b1;
        bus.busPI   = 3'(pi);
        step();
        bus.busACKI = 1'b0;
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        logic [15:0] g;
        logic [15:0] m;
        logic [3:0]  vld;
        logic [17:0] ev;
        int          d, k, doneC, pih, pil, pi;
        bit          et;

        setIn('0, 0, 0);
        bus.statINI    = 1'b0;
        bus.busACKI    = 1'b0;
        bus.busPI      = '0;
        bus.devVECT    = '0;
        bus.devVECTVLD = '0;
        step();
        step();
        chk("reset_outs", {bus.busVECTVLD, bus.setTMO, bus.devACKO, bus.busREQO}, 0);
        chk("reset_vect", bus.busVECT, 0);
        rst = 1'b1;
        step();

        tbl[0] = '{br(2,5), 3, 5, 5, lv(5), br(2,5)};
        tbl[1] = '{br(1,4) | br(3,7) | br(4,6), 2, 2, 2, lv(2), br(3,7)};
        tbl[2] = '{br(1,6) | br(4,6), 2, 2, 2, lv(2), br(1,6)};
        tbl[3] = '{br(2,5), 3, 5, 6, lv(5), 16'd0};
        tbl[4] = '{br(1,7), 0, 4, 4, 7'd0, 16'd0};
        tbl[5] = '{br(3,7) | br(2,4), 6, 1, 1, lv(6) | lv(1), br(2,4)};
        tbl[6] = '{br(4,5) | br(4,4) | br(1,4), 7, 3, 3, lv(3), br(4,5)};
        tbl[7] = '{br(1,6) | br(2,4), 4, 0, 4, lv(4), br(1,6)};

        foreach (tbl[i]) begin
            setIn(tbl[i].intr, tbl[i].pih, tbl[i].pil);
            for (int j = 1; j <= 4; j++)
                vs[j] = (i == 0 && j == 2) ? 18'o224 : 18'($urandom);
            packVect();
            step();
            chk($sformatf("v%0d_req", i), bus.busREQO, tbl[i].req);
            ack(tbl[i].pi);
            chk($sformatf("v%0d_ack", i), bus.devACKO, tbl[i].gnt);
            chk($sformatf("v%0d_vld2", i), bus.busVECTVLD, tbl[i].gnt == 0);
            if (tbl[i].gnt != 0) begin
                d = devOf(tbl[i].gnt);
                bus.devVECTVLD = dv(d);
                step();
                chk($sformatf("v%0d_vld3", i), bus.busVECTVLD, 1);
                chk($sformatf("v%0d_vect", i), bus.busVECT, vs[d]);
                bus.devVECTVLD = '0;
            end else begin
                chk($sformatf("v%0d_vect0", i), bus.busVECT, 0);
            end
            step();
        end

        // Timeout: no vector from the granted device
        setIn(br(1,5), 3, 5);
        step();
        ack(5);
        ok = 1;
        for (int c = 2; c <= TO + 1; c++) begin
            if (c > 2) step();
            if (bus.devACKO !== br(1,5) || bus.busVECTVLD || bus.setTMO) ok = 0;
        end
        chk("tmo_hold", ok, 1);
        step();
        chk("tmo_strobe", bus.setTMO, 1);
        chk("tmo_vld", bus.busVECTVLD, 1);
        chk("tmo_vect", bus.busVECT, 0);
        chk("tmo_ack", bus.devACKO, 0);
        step();
        chk("tmo_after", {bus.setTMO, bus.busVECTVLD, bus.devACKO}, 0);

        // Vector on the last WAIT cycle beats the timeout; other VLD ignored
        vs[1] = 18'o123456;
        vs[3] = 18'o765432;
        packVect();
        ack(5);
        ok = 1;
        for (int c = 2; c <= TO + 1; c++) begin
            if (c > 2) step();
            if (bus.devACKO !== br(1,5) || bus.busVECTVLD || bus.setTMO) ok = 0;
            bus.devVECTVLD = dv(3) | ((c == TO + 1) ? dv(1) : 4'd0);
        end
        chk("edge_hold", ok, 1);
        step();
        bus.devVECTVLD = '0;
        chk("edge_vld", bus.busVECTVLD, 1);
        chk("edge_vect", bus.busVECT, 18'o123456);
        chk("edge_notmo", bus.setTMO, 0);
        step();

        // statINI abort in WAIT; ack during WAIT ignored
        setIn(br(2,7), 7, 1);
        step();
        ack(7);
        chk("ini_ack", bus.devACKO, br(2,7));
        bus.busACKI = 1'b1;
        bus.busPI   = 3'd7;
        step();
        bus.busACKI = 1'b0;
        chk("ini_wait", bus.devACKO, br(2,7));
        bus.statINI = 1'b1;
        step();
        bus.statINI = 1'b0;
        chk("ini_idle", {bus.devACKO, bus.busVECTVLD, bus.setTMO}, 0);
        ok = 1;
        repeat (TO + 4) begin
            step();
            if (bus.devACKO != 0 || bus.busVECTVLD || bus.setTMO) ok = 0;
        end
        chk("ini_quiet", ok, 1);

        // Async reset in WAIT drops outputs without a clock edge
        ack(7);
        chk("rst_pre_ack", bus.devACKO, br(2,7));
        chk("rst_pre_req", bus.busREQO, lv(7));
        #2;
        rst = 1'b0;
        #1;
        chk("rst_mid_outs", {bus.busVECTVLD, bus.setTMO, bus.devACKO, bus.busREQO}, 0);
        chk("rst_mid_vect", bus.busVECT, 0);
        step();
        rst = 1'b1;
        ok = 1;
        repeat (TO + 4) begin
            step();
            if (bus.devACKO != 0 || bus.busVECTVLD || bus.setTMO) ok = 0;
        end
        chk("rst_quiet", ok, 1);

        // Randomized transactions against the model
        for (int t = 0; t < 40; t++) begin
            m = 16'($urandom);
            if (t % 3 == 0) m = m & 16'($urandom);
            pih = $urandom_range(0, 7);
            pil = $urandom_range(0, 7);
            case ($urandom_range(0, 3))
                0: pi = pih;
                1: pi = pil;
                default: pi = $urandom_range(0, 7);
            endcase
            setIn(m, pih, pil);
            for (int j = 1; j <= 4; j++) vs[j] = 18'($urandom);
            packVect();
            step();
            chk($sformatf("r%0d_req", t), bus.busREQO, mReq(m, pih, pil));
            g = mWin(m, pih, pil, pi);
            ack(pi);
            if (g == 0) begin
                chk($sformatf("r%0d_pass", t),
                    {bus.busVECTVLD, bus.setTMO, bus.devACKO, 14'(bus.busVECT)},
                    {1'b1, 1'b0, 16'd0, 14'd0});
                step();
            end else begin
                d = devOf(g);
                k = $urandom_range(0, TO + 2);
                if (k <= TO - 1) begin
                    doneC = 3 + k;
                    ev = vs[d];
                    et = 0;
                end else begin
                    doneC = TO + 2;
                    ev = '0;
                    et = 1;
                end
                ok = 1;
                for (int c = 2; c < doneC; c++) begin
                    if (bus.devACKO !== g || bus.busVECTVLD || bus.setTMO) ok = 0;
                    vld = 4'($urandom) & ~dv(d);
                    if (c >= 2 + k) vld = vld | dv(d);
                    bus.devVECTVLD = vld;
                    step();
                end
                bus.devVECTVLD = '0;
                chk($sformatf("r%0d_hold", t), ok, 1);
                chk($sformatf("r%0d_done", t),
                    {bus.busVECTVLD, bus.setTMO, bus.devACKO}, {1'b1, et, 16'd0});
                chk($sformatf("r%0d_vect", t), bus.busVECT, ev);
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
        $finish;
    end
endmodule
